// File: rtl/collenda_vga_timing.sv
// ============================================================================
// Module   : collenda_vga_timing
// Purpose  : VGA 640x480@60 timing generator with registered, blanked colour
//            output. Optional bar test pattern under COLLENDA_TEST_PATTERN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module collenda_vga_timing #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [2:0] color_r_in,
    input  logic [2:0] color_g_in,
    input  logic [2:0] color_b_in,
    input  logic       pattern_sel,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_req,
    output logic       frame_start,
    output logic [2:0] color_r_readdata,
    output logic [2:0] color_g_readdata,
    output logic [2:0] color_b_readdata,
    output logic       hsync_writeresponsevalid_n,
    output logic       vsync_writeresponsevalid_n,
    output logic       printtingscreen_writeresponsevalid_n
);

    localparam logic [3:0] c_DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] c_H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] c_HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] c_VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] c_V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [3:0] div_q, div_d;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic [2:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic       hs_n_q, hs_n_d, vs_n_q, vs_n_d, de_q, de_d;
    logic       w_tick;
    logic [2:0] w_src_r, w_src_g, w_src_b;

    assign w_tick    = (div_q == c_DIV_LAST);
    assign pixel_x   = h_q;
    assign pixel_y   = v_q;
    assign pixel_req = (h_q < c_H_ACT) && (v_q < c_V_ACT);
    assign frame_start = w_tick && (h_q == 10'd0) && (v_q == 10'd0);

`ifdef COLLENDA_TEST_PATTERN_EN
    // Eight 80-pixel bars; bar index bits map directly onto full-scale r/g/b.
    logic [2:0] w_bar;
    assign w_bar = 3'(h_q / 10'd80);

    always_comb begin
        w_src_r = color_r_in;
        w_src_g = color_g_in;
        w_src_b = color_b_in;
        if (pattern_sel) begin
            w_src_r = w_bar[2] ? 3'd7 : 3'd0;
            w_src_g = w_bar[1] ? 3'd7 : 3'd0;
            w_src_b = w_bar[0] ? 3'd7 : 3'd0;
        end
    end
`else
    logic w_pattern_sel_unused;
    assign w_pattern_sel_unused = pattern_sel;

    always_comb begin
        w_src_r = color_r_in;
        w_src_g = color_g_in;
        w_src_b = color_b_in;
    end
`endif

    always_comb begin
        div_d  = w_tick ? 4'd0 : div_q + 4'd1;
        h_d    = h_q;
        v_d    = v_q;
        r_d    = r_q;
        g_d    = g_q;
        b_d    = b_q;
        hs_n_d = hs_n_q;
        vs_n_d = vs_n_q;
        de_d   = de_q;
        if (w_tick) begin
            if (h_q == c_H_LAST) begin
                h_d = 10'd0;
                v_d = (v_q == c_V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            // Output stage captures the position being left, giving one tick of latency.
            r_d    = pixel_req ? w_src_r : 3'd0;
            g_d    = pixel_req ? w_src_g : 3'd0;
            b_d    = pixel_req ? w_src_b : 3'd0;
            hs_n_d = !((h_q >= c_HS_START) && (h_q < c_HS_END));
            vs_n_d = !((v_q >= c_VS_START) && (v_q < c_VS_END));
            de_d   = pixel_req;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            div_q  <= 4'd0;
            h_q    <= 10'd0;
            v_q    <= 10'd0;
            r_q    <= 3'd0;
            g_q    <= 3'd0;
            b_q    <= 3'd0;
            hs_n_q <= 1'b1;
            vs_n_q <= 1'b1;
            de_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            v_q    <= v_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
            hs_n_q <= hs_n_d;
            vs_n_q <= vs_n_d;
            de_q   <= de_d;
        end
    end

    assign color_r_readdata                     = r_q;
    assign color_g_readdata                     = g_q;
    assign color_b_readdata                     = b_q;
    assign hsync_writeresponsevalid_n           = hs_n_q;
    assign vsync_writeresponsevalid_n           = vs_n_q;
    assign printtingscreen_writeresponsevalid_n = de_q;

endmodule

`default_nettype wire

// File: tb/tb_collenda_vga_timing.sv
// ============================================================================
// Module   : tb_collenda_vga_timing
// Purpose  : Scoreboard bench for collenda_vga_timing with a reduced frame height.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_collenda_vga_timing;

    localparam int DIV = 2;
    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 4, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME_CLK = HT * VT * DIV;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
        logic       hs_n;
        logic       vs_n;
        logic       de;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cr = 3'd0, cg = 3'd0, cb = 3'd0;
    logic       psel = 1'b0;
    logic [9:0] px, py;
    logic       preq, fstart;
    logic [2:0] orr, org, orb;
    logic       hs_n, vs_n, de;

    int   checks = 0;
    int   errors = 0;
    int   mode   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    collenda_vga_timing #(
        .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .color_r_in(cr),
        .color_g_in(cg),
        .color_b_in(cb),
        .pattern_sel(psel),
        .pixel_x(px),
        .pixel_y(py),
        .pixel_req(preq),
        .frame_start(fstart),
        .color_r_readdata(orr),
        .color_g_readdata(org),
        .color_b_readdata(orb),
        .hsync_writeresponsevalid_n(hs_n),
        .vsync_writeresponsevalid_n(vs_n),
        .printtingscreen_writeresponsevalid_n(de)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drives the upstream colour for pixel number p (since reset) and records the
    // response the display should show for it one tick later.
    task automatic drive(input int p);
        int   h, v;
        bit   vis;
        exp_t e;
        h   = p % HT;
        v   = (p / HT) % VT;
        vis = (h < HA) && (v < VA);
        psel = 1'b0;
        case (mode)
            1:       begin cr = 3'b101; cg = 3'b101; cb = 3'b101; end
            2:       begin cr = 3'(h); cg = 3'(h); cb = 3'(h); end
            default: begin cr = 3'($urandom); cg = 3'($urandom); cb = 3'($urandom); end
        endcase
        e.r = cr; e.g = cg; e.b = cb;
`ifdef COLLENDA_TEST_PATTERN_EN
        if (mode == 3) begin
            psel = 1'($urandom);
            if (psel) begin
                e.r = ((h / 80) & 4) != 0 ? 3'd7 : 3'd0;
                e.g = ((h / 80) & 2) != 0 ? 3'd7 : 3'd0;
                e.b = ((h / 80) & 1) != 0 ? 3'd7 : 3'd0;
            end
        end
`endif
        if (!vis) begin e.r = 3'd0; e.g = 3'd0; e.b = 3'd0; end
        e.hs_n = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs_n = !((v >= VA + VF) && (v < VA + VF + VS));
        e.de   = vis;
        q.push_back(e);
    endtask

    // Stimulus: new colour for every pixel position, right after the counters move.
    initial begin : p_driver
        int  n;
        bit  armed;
        n = 0;
        armed = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                if (!armed) begin
                    n = 0;
                    q.delete();
                    drive(0);
                    armed = 1'b1;
                end
            end else begin
                armed = 1'b0;
                n++;
                if (n % DIV == 0) drive(n / DIV);
            end
        end
    end

    // Monitor: counter outputs every clock, scoreboard pop on every pixel tick.
    initial begin : p_monitor
        int   m, pos;
        exp_t e;
        m = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                m = 0;
                chk("rst_pixel_x", px, 0);
                chk("rst_pixel_y", py, 0);
                chk("rst_pixel_req", preq, 1);
                chk("rst_frame_start", fstart, 0);
                chk("rst_color", {orr, org, orb}, 0);
                chk("rst_hsync_n", hs_n, 1);
                chk("rst_vsync_n", vs_n, 1);
                chk("rst_printtingscreen", de, 0);
            end else begin
                m++;
                pos = m / DIV;
                chk("pixel_x", px, pos % HT);
                chk("pixel_y", py, (pos / HT) % VT);
                chk("pixel_req", preq, int'(((pos % HT) < HA) && (((pos / HT) % VT) < VA)));
                chk("frame_start", fstart,
                    int'((m % DIV == DIV - 1) && (pos % (HT * VT) == 0)));
                if (m % DIV == 0) begin
                    if (q.size() == 0) begin
                        chk("scoreboard_empty", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("color_r", orr, e.r);
                        chk("color_g", org, e.g);
                        chk("color_b", orb, e.b);
                        chk("hsync_n", hs_n, e.hs_n);
                        chk("vsync_n", vs_n, e.vs_n);
                        chk("printtingscreen", de, e.de);
                    end
                end
            end
        end
    end

    // Sync pulse widths and periods measured in clocks.
    initial begin : p_periods
        longint cyc, hfall, vfall, fs_last;
        logic   hs_prev, vs_prev;
        cyc = 0; hfall = -1; vfall = -1; fs_last = -1;
        hs_prev = 1'b1; vs_prev = 1'b1;
        forever begin
            @(posedge clk);
            #3;
            cyc++;
            if (rst) begin
                hfall = -1; vfall = -1; fs_last = -1;
                hs_prev = 1'b1; vs_prev = 1'b1;
            end else begin
                if (hs_prev && !hs_n) begin
                    if (hfall >= 0) chk("hsync_period", int'(cyc - hfall), HT * DIV);
                    hfall = cyc;
                end
                if (!hs_prev && hs_n && hfall >= 0) chk("hsync_low", int'(cyc - hfall), HS * DIV);
                if (vs_prev && !vs_n) begin
                    if (vfall >= 0) chk("vsync_period", int'(cyc - vfall), FRAME_CLK);
                    vfall = cyc;
                end
                if (!vs_prev && vs_n && vfall >= 0) chk("vsync_low", int'(cyc - vfall), VS * HT * DIV);
                if (fstart) begin
                    if (fs_last >= 0) chk("frame_start_period", int'(cyc - fs_last), FRAME_CLK);
                    fs_last = cyc;
                end
                hs_prev = hs_n;
                vs_prev = vs_n;
            end
        end
    end

    initial begin : p_main
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        repeat (8537) @(posedge clk);
        #4 rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        mode = 0;
        repeat (18000) @(posedge clk);
        mode = 1;
        repeat (2 * HT * DIV) @(posedge clk);
        mode = 2;
        repeat (2 * HT * DIV) @(posedge clk);
`ifdef COLLENDA_TEST_PATTERN_EN
        mode = 3;
        repeat (2 * HT * DIV) @(posedge clk);
`endif
        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/collenda_vga_timing.md
# collenda_vga_timing

VGA 640x480@60 timing generator and pixel output stage. It feeds the display side of the collenda system: it produces the `hsync`/`vsync` strobes, the `printtingscreen` active-video flag and the 3-bit-per-channel colour bus. Each pixel is fetched from an upstream pixel source by coordinate, then registered and blanked outside the visible area.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel tick (50 MHz to 25 MHz); legal values 1..15.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixel ticks.
- `H_SYNC`, 96: horizontal sync width, in pixel ticks.
- `H_BP`, 48: horizontal back porch, in pixel ticks.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk_clk`  in  1  system clock; all logic is on its rising edge.
- `reset_reset`  in  1  asynchronous reset, active-high.
- `color_r_in`, `color_g_in`, `color_b_in`  in  3 each  pixel colour from the upstream source for (`pixel_x`,`pixel_y`).
- `pattern_sel`  in  1  selects the test pattern; used only when the test pattern is compiled in (see Configuration).
- `pixel_x`  out  10  current horizontal counter.
- `pixel_y`  out  10  current vertical counter.
- `pixel_req`  out  1  high while (`pixel_x`,`pixel_y`) is inside the visible area.
- `frame_start`  out  1  one-clock pulse at the start of each frame.
- `color_r_readdata`, `color_g_readdata`, `color_b_readdata`  out  3 each  registered, blanked colour.
- `hsync_writeresponsevalid_n`  out  1  horizontal sync, active-low.
- `vsync_writeresponsevalid_n`  out  1  vertical sync, active-low.
- `printtingscreen_writeresponsevalid_n`  out  1  registered active-video flag, active-high despite the `_n` suffix.

## Operation
- **Divider:** `div` counts 0..CLK_DIV-1 on every clock. `tick` = (`div` == CLK_DIV-1).
- **Horizontal counter:** `h` counts 0..H_TOTAL-1 (H_TOTAL = 800) and advances on `tick`.
  - Horizontal state is derived from `h`: ACTIVE [0,640), FRONT [640,656), SYNC [656,752), BACK [752,800).
  - Wrap: at `h` = 799 on `tick`, `h` goes to 0 and `v` increments.
- **Vertical counter:** `v` counts 0..524.
  - Vertical state: ACTIVE [0,480), FRONT [480,490), SYNC [490,492), BACK [492,525).
  - `v` wraps from 524 to 0.
- **Pixel request:** `pixel_x` = `h`, `pixel_y` = `v`. `pixel_req` = (h < H_ACTIVE) && (v < V_ACTIVE), combinational from the counter registers.
- **Output register:** loads on `tick`, from the pre-increment `h`/`v`:
  - colour = `pixel_req` ? colour_in : 0
  - `hsync_n` = !(h in SYNC)
  - `vsync_n` = !(v in SYNC)
  - `printtingscreen` = `pixel_req`
- **Frame start:** `frame_start` is high for exactly one clock, on the clock where `tick` && h==0 && v==0.
- **Counter widths:** counters are 10 bits. No arithmetic beyond +1 with compare-and-clear; there are no overflow paths.

## Timing
- **Reset values:** `div`, `h`, `v` = 0. All colour outputs 0. Both syncs 1. `printtingscreen` 0. `frame_start` 0. `pixel_req` evaluates to 1 (position 0,0).
- **Reset timing:** reset asserts asynchronously, mid-line or mid-frame, and takes effect immediately. The first `tick` after release falls on the CLK_DIV-th rising edge.
- **Latency:** outputs lag `pixel_x`/`pixel_y` by exactly one pixel tick (CLK_DIV clocks). Colour and syncs are always mutually aligned.
- **Upstream handshake:** the source must hold colour_in stable for the current coordinate from the clock after the counters change until `tick`, which gives a CLK_DIV-1 clock window. There is no backpressure; the stream never stalls.
- **Frame period:** line = 800 ticks = 1600 clocks at CLK_DIV=2. Frame = 525 lines = 840000 clocks.

## Configuration
- **`COLLENDA_TEST_PATTERN_EN` defined:** when `pattern_sel`=1, colour_in is replaced by 8 vertical bars of 80 pixels each. Bar index i = `h`[9:0]/80, driven as {r,g,b} = {i[2]?7:0, i[1]?7:0, i[0]?7:0}. Blanking and latency are unchanged.
- **`COLLENDA_TEST_PATTERN_EN` undefined:** `pattern_sel` is ignored and colour_in always passes through.

## Test plan
- **Reset values:** assert reset for 3 clocks mid-frame. Required: syncs=1, colour=0, `printtingscreen`=0, `pixel_x`=`pixel_y`=0. The first `tick` is 2 clocks after release.
- **Hsync (CLK_DIV=2):** `hsync_n` falls 1 tick after `pixel_x`=656 and stays low 192 clocks. Period is 1600 clocks.
- **Vsync:** low for exactly 2 lines (3200 clocks), starting 1 tick after `pixel_y`=490 with `pixel_x`=0. Period is 840000 clocks. `frame_start` pulses once per frame.
- **Blanking:** colour_in=3'b101 held constant. Required: output colour=5 while `printtingscreen`=1, and 0 during porches and sync.
- **Alignment:** colour_in = `pixel_x`[2:0]. Required: output equals x[2:0] of the previous tick's `pixel_x` across the 639 to 640 edge.
- **Test pattern (`COLLENDA_TEST_PATTERN_EN`, `pattern_sel`=1):** pixel 85 → {0,0,7}. Pixel 639 → {7,7,7}.
